// File: rtl/calc_pkg.sv
// Shared types for the calculator responder: command/response codes, slot state and slot contents.
package calc_pkg;

    localparam int NUM_PORTS   = 4;
    localparam int CALC_DATA_W = 32;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_OK     = 2'd1,
        RESP_INERR  = 2'd2,
        RESP_INTERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_OP2  = 2'd1,
        SLOT_PEND = 2'd2
    } slot_state_e;

    // cmd kept as raw bits so unsupported opcodes survive until the ALU flags them
    typedef struct packed {
        logic [3:0]             cmd;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } slot_t;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: single-cycle combinational ALU; add/sub overflow and unknown opcodes give RESP_INERR with zero data.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [3:0]        cmd_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    output resp_e             resp_o,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W:0] sum;
    assign sum = {1'b0, op1_i} + {1'b0, op2_i};

    always_comb begin
        resp_o   = RESP_INERR;
        result_o = '0;
        case (cmd_i)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp_o   = RESP_OK;
                    result_o = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2_i <= op1_i) begin
                    resp_o   = RESP_OK;
                    result_o = op1_i - op2_i;
                end
            end
            CMD_SHL: begin
                resp_o   = RESP_OK;
                result_o = op1_i << op2_i[SHAMT_W-1:0];
            end
            CMD_SHR: begin
                resp_o   = RESP_OK;
                result_o = op1_i >> op2_i[SHAMT_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// calc_port_responder: 4-port calc responder, cmd at edge N -> 1-cycle response after N+3 (+1 per lost grant).
// No backpressure: commands to a busy slot are dropped. CALC_ROUND_ROBIN_EN selects round-robin arbitration.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DATA_W  = CALC_DATA_W,
    parameter int SHAMT_W = $clog2(CALC_DATA_W)
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [1:0]        out_resp1,
    output logic [DATA_W-1:0] out_data1,
    output logic [1:0]        out_resp2,
    output logic [DATA_W-1:0] out_data2,
    output logic [1:0]        out_resp3,
    output logic [DATA_W-1:0] out_data3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data4
);

    logic [3:0]        cmd_in  [NUM_PORTS];
    logic [DATA_W-1:0] data_in [NUM_PORTS];

    assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;
    assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;
    assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;
    assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;

    slot_state_e          st_q   [NUM_PORTS];
    slot_state_e          st_d   [NUM_PORTS];
    slot_t                slot_q [NUM_PORTS];
    slot_t                slot_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic                 gnt_vld;
    logic [1:0]           gnt_idx;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                st_q[i]   <= SLOT_IDLE;
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                st_q[i]   <= st_d[i];
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            st_d[i]   = st_q[i];
            slot_d[i] = slot_q[i];
            case (st_q[i])
                SLOT_IDLE: begin
                    if (cmd_in[i] != 4'd0) begin
                        st_d[i]       = SLOT_OP2;
                        slot_d[i].cmd = cmd_in[i];
                        slot_d[i].op1 = data_in[i];
                    end
                end
                SLOT_OP2: begin
                    st_d[i]       = SLOT_PEND;
                    slot_d[i].op2 = data_in[i];
                end
                SLOT_PEND: begin
                    if (gnt_oh[i]) st_d[i] = SLOT_IDLE;
                end
                default: st_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pend[i] = (st_q[i] == SLOT_PEND);
        end
    end

`ifdef CALC_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_idx;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset)        rr_ptr_q <= 2'd0;
        else if (gnt_vld) rr_ptr_q <= gnt_idx + 2'd1;
    end

    // first pending slot at or after the pointer, wrapping
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        rr_idx  = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_idx = rr_ptr_q + 2'(k);
            if (!gnt_vld && pend[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!gnt_vld && pend[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'(k);
            end
        end
    end
`endif

    assign gnt_oh = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;

    // granted slot is copied out so the port can reload its slot immediately
    logic       ex_vld_q;
    logic [1:0] ex_port_q;
    slot_t      ex_slot_q;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ex_vld_q  <= 1'b0;
            ex_port_q <= 2'd0;
            ex_slot_q <= '0;
        end else begin
            ex_vld_q <= gnt_vld;
            if (gnt_vld) begin
                ex_port_q <= gnt_idx;
                ex_slot_q <= slot_q[gnt_idx];
            end
        end
    end

    resp_e             alu_resp;
    logic [DATA_W-1:0] alu_res;

    calc_alu #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .cmd_i    (ex_slot_q.cmd),
        .op1_i    (ex_slot_q.op1),
        .op2_i    (ex_slot_q.op2),
        .resp_o   (alu_resp),
        .result_o (alu_res)
    );

    resp_e             resp_q [NUM_PORTS];
    logic [DATA_W-1:0] data_q [NUM_PORTS];

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                resp_q[i] <= RESP_NONE;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (ex_vld_q && (ex_port_q == 2'(i))) begin
                    resp_q[i] <= alu_resp;
                    data_q[i] <= alu_res;
                end else begin
                    resp_q[i] <= RESP_NONE;
                    data_q[i] <= '0;
                end
            end
        end
    end

    assign out_resp1 = resp_q[0];  assign out_data1 = data_q[0];
    assign out_resp2 = resp_q[1];  assign out_data2 = data_q[1];
    assign out_resp3 = resp_q[2];  assign out_data3 = data_q[2];
    assign out_resp4 = resp_q[3];  assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc_port_responder.sv
// Randomized and directed bench for calc_port_responder against a transaction-level reference model.
module tb_calc_port_responder;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd_r [4];
    logic [31:0] dat_r [4];
    logic [1:0]  out_resp_w [4];
    logic [31:0] out_data_w [4];

    int n_chk = 0;
    int n_bad = 0;

    always #5 c_clk = ~c_clk;

    calc_port_responder dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_r[0]), .req1_data_in (dat_r[0]),
        .req2_cmd_in  (cmd_r[1]), .req2_data_in (dat_r[1]),
        .req3_cmd_in  (cmd_r[2]), .req3_data_in (dat_r[2]),
        .req4_cmd_in  (cmd_r[3]), .req4_data_in (dat_r[3]),
        .out_resp1    (out_resp_w[0]), .out_data1 (out_data_w[0]),
        .out_resp2    (out_resp_w[1]), .out_data2 (out_data_w[1]),
        .out_resp3    (out_resp_w[2]), .out_data3 (out_data_w[2]),
        .out_resp4    (out_resp_w[3]), .out_data4 (out_data_w[3])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: each accepted request records its arrival edge; it may
    // be granted from two edges later, and its answer shows one edge after grant.
    int          ecnt;
    int          rr_ptr;
    bit          m_act [4];
    int          m_t   [4];
    logic [3:0]  m_cmd [4];
    logic [31:0] m_op1 [4];
    logic [31:0] m_op2 [4];
    logic [1:0]  st_resp  [4];
    logic [31:0] st_data  [4];
    logic [1:0]  now_resp [4];
    logic [31:0] now_data [4];

    function automatic void ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        r = 2'b10;
        d = 32'h0;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s <= 64'hFFFF_FFFF) begin r = 2'b01; d = 32'(s); end
            end
            4'd2: if (b <= a) begin r = 2'b01; d = a - b; end
            4'd5: begin r = 2'b01; d = a << (b % 32); end
            4'd6: begin r = 2'b01; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            m_act[p] = 0;
            st_resp[p] = 0;  st_data[p] = 0;
            now_resp[p] = 0; now_data[p] = 0;
        end
        rr_ptr = 0;
    endtask

    task automatic model_edge();
        int w;
        int p;
        w = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef CALC_ROUND_ROBIN_EN
            p = (rr_ptr + k) % 4;
`else
            p = k;
`endif
            if (w < 0 && m_act[p] && ecnt >= m_t[p] + 2) w = p;
        end
        for (int q = 0; q < 4; q++) begin
            now_resp[q] = st_resp[q];
            now_data[q] = st_data[q];
            st_resp[q] = 0;
            st_data[q] = 0;
        end
        if (w >= 0) ref_calc(m_cmd[w], m_op1[w], m_op2[w], st_resp[w], st_data[w]);
        for (int q = 0; q < 4; q++) begin
            if (m_act[q]) begin
                if (ecnt == m_t[q] + 1) m_op2[q] = dat_r[q];
            end else if (cmd_r[q] != 4'd0) begin
                m_act[q] = 1;
                m_t[q]   = ecnt;
                m_cmd[q] = cmd_r[q];
                m_op1[q] = dat_r[q];
            end
        end
        if (w >= 0) begin
            m_act[w] = 0;
            rr_ptr = (w + 1) % 4;
        end
        ecnt++;
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge, commands then cleared.
    task automatic tick();
        @(posedge c_clk);
        model_edge();
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("resp%0d", p + 1), {30'b0, out_resp_w[p]}, {30'b0, now_resp[p]});
            chk($sformatf("data%0d", p + 1), out_data_w[p], now_data[p]);
        end
        for (int p = 0; p < 4; p++) cmd_r[p] = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) cmd_r[p] = 4'd0;
        model_clear();
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rst_resp%0d", p + 1), {30'b0, out_resp_w[p]}, 32'd0);
            chk($sformatf("rst_data%0d", p + 1), out_data_w[p], 32'd0);
        end
        @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b0;
    endtask

    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd_r[p] = c;
        dat_r[p] = a;
        tick();
        dat_r[p] = b;
        tick();
    endtask

    int cnt;

    initial begin
        ecnt = 0;
        for (int p = 0; p < 4; p++) begin cmd_r[p] = 4'd0; dat_r[p] = 32'd0; end
        @(negedge c_clk);
        do_reset();

        // add on each port: quiet after N+2, single-cycle answer after N+3
        for (int p = 0; p < 4; p++) begin
            issue(p, 4'd1, 32'h8000_2345, 32'h0001_0000);
            tick();
            chk($sformatf("lat_n2_p%0d", p + 1), {30'b0, out_resp_w[p]}, 32'd0);
            tick();
            chk($sformatf("add_resp_p%0d", p + 1), {30'b0, out_resp_w[p]}, 32'd1);
            chk($sformatf("add_data_p%0d", p + 1), out_data_w[p], 32'h8001_2345);
            tick();
            chk($sformatf("one_cycle_p%0d", p + 1), {30'b0, out_resp_w[p]}, 32'd0);
        end

        issue(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        repeat (2) tick();
        chk("add_carry_resp", {30'b0, out_resp_w[1]}, 32'd2);
        chk("add_carry_data", out_data_w[1], 32'd0);
        issue(2, 4'd2, 32'h5, 32'h7);
        repeat (2) tick();
        chk("sub_under_resp", {30'b0, out_resp_w[2]}, 32'd2);
        issue(3, 4'd3, 32'h1234, 32'h1);
        repeat (2) tick();
        chk("bad_cmd_resp", {30'b0, out_resp_w[3]}, 32'd2);

        issue(0, 4'd5, 32'h0000_2000, 32'h1);
        repeat (2) tick();
        chk("shl_data", out_data_w[0], 32'h0000_4000);
        issue(0, 4'd6, 32'h0000_2000, 32'h21);
        repeat (2) tick();
        chk("shr_data", out_data_w[0], 32'h0000_1000);

        // ports 1 and 3 contend
        cmd_r[0] = 4'd1; dat_r[0] = 32'h2000;
        cmd_r[2] = 4'd1; dat_r[2] = 32'h2000;
        tick();
        dat_r[0] = 32'h1; dat_r[2] = 32'h1;
        tick();
        tick();
        tick();
        chk("cont_p1_first", out_data_w[0], 32'h2001);
        chk("cont_p3_waits", {30'b0, out_resp_w[2]}, 32'd0);
        tick();
        chk("cont_p3_second", out_data_w[2], 32'h2001);
        repeat (2) tick();

        // new command during OP2 is dropped; one issued in the response cycle is accepted
        cnt = 0;
        cmd_r[1] = 4'd1; dat_r[1] = 32'h10;
        tick();
        cmd_r[1] = 4'd2; dat_r[1] = 32'h20;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (out_resp_w[1] != 2'b00) begin
                cnt++;
                if (cnt == 1) begin cmd_r[1] = 4'd1; dat_r[1] = 32'h7; end
                else if (cnt == 2) cmd_r[1] = 4'd0;
            end else if (cnt == 1 && cmd_r[1] == 4'd0) begin
                dat_r[1] = 32'h3;
            end
            tick();
            if (out_resp_w[1] == 2'b00 && cnt == 1) cmd_r[1] = 4'd0;
        end
        chk("op2_drop_count", cnt, 32'd2);
        repeat (4) tick();

        // reset while a request is in flight
        issue(0, 4'd1, 32'h1, 32'h2);
        tick();
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int p = 0; p < 4; p++) if (out_resp_w[p] != 2'b00) cnt++;
        end
        chk("post_reset_silent", cnt, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 7))
                    0: cmd_r[p] = 4'd1;
                    1: cmd_r[p] = 4'd2;
                    2: cmd_r[p] = 4'd5;
                    3: cmd_r[p] = 4'd6;
                    4: cmd_r[p] = 4'($urandom_range(0, 15));
                    default: cmd_r[p] = 4'd0;
                endcase
                dat_r[p] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
            end
            tick();
        end
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
